chain_run_controller: RTL and testbench

- Sequences a cascaded tc/enable counter chain built from the project2 counter stages: clears it, enables its first stage, and watches every stage's terminal count.
- Stops the run on a programmed number of final-stage wraps, a cycle budget, or an abort.
- Reports run length, which stages have reached terminal count, and why the run ended.
- Sits between the board-level control inputs and the counter chain top level.

---
 rtl/chain_run_controller.sv | 160 ++++++++++++++++
 tb/tb_chain_run_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_run_controller.sv
// Run controller for a cascaded tc/enable counter chain: clears the chain, enables stage 0,
// monitors terminal counts and ends the run on wrap target, cycle budget or abort.
module chain_run_controller #(
    parameter int NUM_STAGES   = 8,
    parameter int CNT_W        = 32,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      target_wraps,
    input  logic [CNT_W-1:0]      cycle_budget,
    input  logic [NUM_STAGES-1:0] stage_tc,
    output logic                  chain_enable,
    output logic                  chain_clear,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            done_reason,
    output logic [CNT_W-1:0]      cycles_run,
    output logic [CNT_W-1:0]      wrap_count,
    output logic [NUM_STAGES-1:0] tc_seen
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    localparam logic [1:0] REASON_NONE     = 2'd0;
    localparam logic [1:0] REASON_COMPLETE = 2'd1;
    localparam logic [1:0] REASON_BUDGET   = 2'd2;
    localparam logic [1:0] REASON_ABORT    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]        cycles_q, cycles_d;
    logic [CNT_W-1:0]        wraps_q, wraps_d;
    logic [NUM_STAGES-1:0]   seen_q, seen_d;
    logic [1:0]              reason_q, reason_d;
    logic [CNT_W-1:0]        target_q, target_d;
    logic [CNT_W-1:0]        budget_q, budget_d;

    logic [CNT_W-1:0]        run_cycles;
    logic [CNT_W-1:0]        run_wraps;
    logic [NUM_STAGES-1:0]   run_seen;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cycles_d  = cycles_q;
        wraps_d   = wraps_q;
        seen_d    = seen_q;
        reason_d  = reason_q;
        target_d  = target_q;
        budget_d  = budget_q;

        // Exit decisions in RUN look at the counters as they will be after this cycle.
        run_cycles = sat_inc(cycles_q);
        run_wraps  = stage_tc[NUM_STAGES-1] ? sat_inc(wraps_q) : wraps_q;
        run_seen   = seen_q | stage_tc;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    cycles_d  = '0;
                    wraps_d   = '0;
                    seen_d    = '0;
                    reason_d  = REASON_NONE;
                    target_d  = (target_wraps == '0) ? CNT_W'(1) : target_wraps;
                    budget_d  = cycle_budget;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            S_RUN: begin
                cycles_d = run_cycles;
                wraps_d  = run_wraps;
                seen_d   = run_seen;
                if (run_wraps >= target_q) begin
                    state_d  = S_DONE;
                    reason_d = REASON_COMPLETE;
                end else if ((budget_q != '0) && (run_cycles >= budget_q)) begin
                    state_d  = S_DONE;
                    reason_d = REASON_BUDGET;
                end else if (stop) begin
                    state_d  = S_DONE;
                    reason_d = REASON_ABORT;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d  = S_DONE;
                    reason_d = REASON_ABORT;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            cycles_q  <= '0;
            wraps_q   <= '0;
            seen_q    <= '0;
            reason_q  <= REASON_NONE;
            target_q  <= '0;
            budget_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cycles_q  <= cycles_d;
            wraps_q   <= wraps_d;
            seen_q    <= seen_d;
            reason_q  <= reason_d;
            target_q  <= target_d;
            budget_q  <= budget_d;
        end
    end

    // Chain controls are pure state decodes so no input can reach an output combinationally.
    assign chain_enable = (state_q == S_RUN);
    assign chain_clear  = (state_q == S_CLEAR);
    assign busy         = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done         = (state_q == S_DONE);
    assign done_reason  = reason_q;
    assign cycles_run   = cycles_q;
    assign wrap_count   = wraps_q;
    assign tc_seen      = seen_q;

endmodule

// File: tb/tb_chain_run_controller.sv
// Scoreboard bench for chain_run_controller: a run-level reference model predicts each run's
// outcome, a monitor checks the DUT's reported results whenever done pulses.
module tb_chain_run_controller;

    localparam int NS   = 4;
    localparam int CW   = 16;
    localparam int CC   = 2;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          reset, start, pause, stop;
    logic [CW-1:0] target_wraps, cycle_budget;
    logic [NS-1:0] stage_tc;
    logic          chain_enable, chain_clear, busy, done;
    logic [1:0]    done_reason;
    logic [CW-1:0] cycles_run, wrap_count;
    logic [NS-1:0] tc_seen;

    chain_run_controller #(.NUM_STAGES(NS), .CNT_W(CW), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .target_wraps(target_wraps), .cycle_budget(cycle_budget), .stage_tc(stage_tc),
        .chain_enable(chain_enable), .chain_clear(chain_clear), .busy(busy), .done(done),
        .done_reason(done_reason), .cycles_run(cycles_run), .wrap_count(wrap_count),
        .tc_seen(tc_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    reason;
        int            cycles;
        int            wraps;
        logic [NS-1:0] seen;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Scenario description: per-RUN-cycle stage_tc values plus control events.
    logic [NS-1:0] tc_arr[MAXC+1];
    int s_tgt, s_budget, s_stop_at, s_pause_at, s_pause_len;
    bit s_pause_stop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {chain_enable, chain_clear, busy, done, done_reason, cycles_run,
                     wrap_count, tc_seen}, 64'd0);
    endtask

    task automatic clear_scn();
        for (int i = 0; i <= MAXC; i++) tc_arr[i] = '0;
        s_tgt = 1; s_budget = 0; s_stop_at = 0; s_pause_at = 0; s_pause_len = 1;
        s_pause_stop = 0;
    endtask

    // Walk the RUN cycles applying the exit rules in priority order.
    task automatic model(output exp_t e, output int end_i, output bit in_pause);
        int            w;
        int            t;
        logic [NS-1:0] s;
        w = 0; s = '0; t = (s_tgt == 0) ? 1 : s_tgt;
        e.reason = 2'd0; e.cycles = 0; e.wraps = 0; e.seen = '0;
        end_i = 0; in_pause = 0;
        for (int i = 1; i <= MAXC && end_i == 0; i++) begin
            s = s | tc_arr[i];
            if (tc_arr[i][NS-1]) w++;
            if (w >= t) e.reason = 2'd1;
            else if (s_budget != 0 && i >= s_budget) e.reason = 2'd2;
            else if (i == s_stop_at) e.reason = 2'd3;
            else if (i == s_pause_at && s_pause_stop) begin
                e.reason = 2'd3;
                in_pause = 1;
            end
            if (e.reason != 2'd0) begin
                end_i = i; e.cycles = i; e.wraps = w; e.seen = s;
            end
        end
    endtask

    task automatic run_scenario(input string tag);
        exp_t          e;
        int            end_i;
        bit            in_pause;
        logic [NS-1:0] acc;
        acc = '0;
        model(e, end_i, in_pause);
        check({tag, "_scenario_ends"}, (end_i != 0), 1);
        if (end_i == 0) return;
        exp_q.push_back(e);

        target_wraps = CW'(s_tgt);
        cycle_budget = CW'(s_budget);
        stage_tc     = NS'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        // Later changes must be ignored until the next start.
        target_wraps = CW'($urandom);
        cycle_budget = CW'($urandom_range(1, 3));

        for (int c = 0; c < CC; c++) begin
            check({tag, "_clear_high"}, {chain_clear, chain_enable, busy}, 3'b101);
            stage_tc = NS'($urandom);
            stop     = 1'($urandom);
            pause    = 1'($urandom);
            start    = 1'($urandom);
            step();
        end
        stop = 1'b0; pause = 1'b0; start = 1'b0;

        for (int i = 1; i <= end_i; i++) begin
            check({tag, "_run_ctrl"}, {chain_clear, chain_enable, busy}, 3'b011);
            stage_tc = tc_arr[i];
            stop     = (i == s_stop_at);
            pause    = (i == s_pause_at);
            start    = 1'($urandom);
            step();
            stop = 1'b0; pause = 1'b0; start = 1'b0;
            acc = acc | tc_arr[i];
            if (i < end_i) check({tag, "_cycles_run"}, cycles_run, i);
            if (i == s_pause_at && (i < end_i || in_pause)) begin
                for (int p = 0; p < s_pause_len; p++) begin
                    check({tag, "_pause_enable"}, {chain_enable, busy}, 2'b01);
                    check({tag, "_pause_frozen"}, {cycles_run, tc_seen}, {CW'(i), acc});
                    stage_tc = NS'($urandom);
                    step();
                end
                if (in_pause) begin
                    stop  = 1'b1;
                    start = 1'($urandom);
                end else begin
                    start = 1'b1;
                end
                step();
                stop = 1'b0; start = 1'b0;
            end
        end
        check({tag, "_done_pulse"}, {done, busy, chain_enable}, 3'b100);
        stage_tc = NS'($urandom);
        step();
        check({tag, "_done_end"}, {done, busy}, 2'b00);
        check({tag, "_hold_reason"}, done_reason, e.reason);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_reason", done_reason, mon_e.reason);
                check("sb_cycles", cycles_run, mon_e.cycles);
                check("sb_wraps", wrap_count, mon_e.wraps);
                check("sb_tc_seen", tc_seen, mon_e.seen);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        target_wraps = '0; cycle_budget = '0; stage_tc = '0;
        step(); step();
        check_all_zero("reset_state");
        reset = 1'b0;
        step();
        check_all_zero("after_release");

        // stop and pause in IDLE do nothing
        stop = 1'b1; pause = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0;
        check("idle_stop_ignored", {busy, done, chain_clear}, 3'b000);

        // Asynchronous reset in the middle of a run
        target_wraps = CW'(1); cycle_budget = '0; stage_tc = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (CC + 6) step();
        check("enable_before_reset", {chain_enable, cycles_run}, {1'b1, CW'(6)});
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        step();
        reset = 1'b0;
        step();

        clear_scn();
        s_tgt = 3; s_budget = 0;
        tc_arr[5] = 4'b0001; tc_arr[10] = 4'b1000; tc_arr[20] = 4'b1000; tc_arr[30] = 4'b1000;
        run_scenario("complete");

        clear_scn();
        s_tgt = 5; s_budget = 25;
        for (int i = 1; i <= MAXC; i++) tc_arr[i] = NS'($urandom_range(0, 7));
        run_scenario("budget");

        clear_scn();
        s_tgt = 3; s_budget = 30; s_stop_at = 30;
        tc_arr[10] = 4'b1000; tc_arr[20] = 4'b1010; tc_arr[30] = 4'b1000;
        run_scenario("tie_priority");

        clear_scn();
        s_tgt = 9; s_budget = 15; s_pause_at = 5; s_pause_len = 8;
        tc_arr[3] = 4'b0100; tc_arr[7] = 4'b0010;
        run_scenario("pause_resume");

        clear_scn();
        s_tgt = 9; s_budget = 0; s_pause_at = 5; s_pause_len = 3; s_pause_stop = 1;
        tc_arr[2] = 4'b1001;
        run_scenario("pause_stop");

        clear_scn();
        s_tgt = 0; s_budget = 0; tc_arr[7] = 4'b1000;
        run_scenario("target_zero");

        clear_scn();
        s_tgt = 4; s_budget = 0; s_stop_at = 12; tc_arr[4] = 4'b1100;
        run_scenario("run_stop");

        for (int k = 0; k < 12; k++) begin
            clear_scn();
            s_tgt    = $urandom_range(0, 4);
            s_budget = $urandom_range(5, 40);
            for (int i = 1; i <= MAXC; i++)
                tc_arr[i] = {1'($urandom_range(0, 5) == 0), 3'($urandom)};
            s_stop_at    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            s_pause_at   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 40) : 0;
            s_pause_len  = $urandom_range(1, 6);
            s_pause_stop = 1'($urandom);
            run_scenario("random");
        end

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
